// File: rtl/frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : frame_receiver
//  Description : Loopback receiver for the delay tester. Arms on tx_start,
//                counts tx_clk cycles until the first looped-back byte,
//                checks destination MAC / EtherType / length / MAC status,
//                and reports delay plus running ok/error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_receiver #(
  parameter logic [47:0] EXP_DST_ADDR   = 48'hFFFF_FFFF_FFFF,
  parameter logic [15:0] EXP_ETH_TYPE   = 16'h0806,
  parameter int          MIN_FRAME_LEN  = 60,
  parameter int          MAX_FRAME_LEN  = 1518,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter int          CNT_WIDTH      = 32
) (
  input  logic                 tx_clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [7:0]           mac_rx_data,
  input  logic                 mac_rx_dvld,
  input  logic                 mac_rx_good_frame,
  input  logic                 mac_rx_bad_frame,
  output logic [CNT_WIDTH-1:0] delay_cycles,
  output logic                 delay_valid,
  output logic [11:0]          frame_len,
  output logic [15:0]          rx_ok_count,
  output logic [15:0]          rx_err_count,
  output logic                 timeout,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_ARMED       = 3'd1,
    S_RX_HDR      = 3'd2,
    S_RX_PAYLOAD  = 3'd3,
    S_WAIT_STATUS = 3'd4,
    S_REPORT      = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [11:0]          LEN_MIN     = 12'(MIN_FRAME_LEN);
  localparam logic [11:0]          LEN_MAX     = 12'(MAX_FRAME_LEN);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] cap_delay_q, cap_delay_d;
  logic [11:0]          len_q, len_d;
  logic                 mismatch_q, mismatch_d;
  logic                 runt_q, runt_d;
  logic                 good_lat_q, good_lat_d;
  logic                 bad_lat_q, bad_lat_d;
  logic [3:0]           wait_cnt_q, wait_cnt_d;
  logic                 dvld_prev_q, dvld_prev_d;
  logic [CNT_WIDTH-1:0] delay_cycles_q, delay_cycles_d;
  logic                 delay_valid_q, delay_valid_d;
  logic [11:0]          frame_len_q, frame_len_d;
  logic [15:0]          ok_cnt_q, ok_cnt_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;
  logic                 dvld_rise;
  logic                 accept;

  // Returns 1 when a header byte at position idx differs from the expected
  // value; positions outside the checked fields never mismatch.
  function automatic logic hdr_mismatch(input logic [11:0] idx, input logic [7:0] data);
    logic r;
    r = 1'b0;
    case (idx)
      12'd0:   r = (data != EXP_DST_ADDR[47:40]);
      12'd1:   r = (data != EXP_DST_ADDR[39:32]);
      12'd2:   r = (data != EXP_DST_ADDR[31:24]);
      12'd3:   r = (data != EXP_DST_ADDR[23:16]);
      12'd4:   r = (data != EXP_DST_ADDR[15:8]);
      12'd5:   r = (data != EXP_DST_ADDR[7:0]);
      12'd12:  r = (data != EXP_ETH_TYPE[15:8]);
      12'd13:  r = (data != EXP_ETH_TYPE[7:0]);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Next-state and next-output computation for the whole receiver.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cap_delay_d    = cap_delay_q;
    len_d          = len_q;
    mismatch_d     = mismatch_q;
    runt_d         = runt_q;
    good_lat_d     = good_lat_q;
    bad_lat_d      = bad_lat_q;
    wait_cnt_d     = wait_cnt_q;
    delay_cycles_d = delay_cycles_q;
    frame_len_d    = frame_len_q;
    ok_cnt_d       = ok_cnt_q;
    err_cnt_d      = err_cnt_q;
    delay_valid_d  = 1'b0;
    timeout_d      = 1'b0;
    dvld_prev_d    = mac_rx_dvld;
    dvld_rise      = mac_rx_dvld & ~dvld_prev_q;
    accept         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // RX traffic here is unsolicited and deliberately ignored.
        if (tx_start) begin
          state_d = S_ARMED;
          cnt_d   = CNT_ONE;
        end
      end

      S_ARMED: begin
        if (dvld_rise) begin
          // First byte: capture the delay and start a fresh frame record.
          cap_delay_d = cnt_q;
          len_d       = 12'd1;
          mismatch_d  = hdr_mismatch(12'd0, mac_rx_data);
          runt_d      = 1'b0;
          good_lat_d  = 1'b0;
          bad_lat_d   = 1'b0;
          wait_cnt_d  = 4'd0;
          state_d     = S_RX_HDR;
        end else if (tx_start) begin
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_TIMEOUT) begin
          timeout_d = 1'b1;
          err_cnt_d = sat_inc16(err_cnt_q);
          state_d   = S_IDLE;
        end else if (~&cnt_q) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RX_HDR: begin
        good_lat_d = good_lat_q | mac_rx_good_frame;
        bad_lat_d  = bad_lat_q | mac_rx_bad_frame;
        if (mac_rx_dvld) begin
          mismatch_d = mismatch_q | hdr_mismatch(len_q, mac_rx_data);
          len_d      = len_q + 12'd1;
          if (len_q == 12'd13) state_d = S_RX_PAYLOAD;
        end else begin
          runt_d  = 1'b1;
          state_d = S_WAIT_STATUS;
        end
      end

      S_RX_PAYLOAD: begin
        good_lat_d = good_lat_q | mac_rx_good_frame;
        bad_lat_d  = bad_lat_q | mac_rx_bad_frame;
        if (mac_rx_dvld) begin
          if (len_q != 12'hFFF) len_d = len_q + 12'd1;
        end else begin
          state_d = S_WAIT_STATUS;
        end
      end

      S_WAIT_STATUS: begin
        good_lat_d = good_lat_q | mac_rx_good_frame;
        bad_lat_d  = bad_lat_q | mac_rx_bad_frame;
        if (good_lat_d | bad_lat_d) begin
          state_d = S_REPORT;
        end else if (wait_cnt_q == 4'd15) begin
          // Missing MAC status is treated as a bad frame.
          bad_lat_d = 1'b1;
          state_d   = S_REPORT;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      S_REPORT: begin
        frame_len_d = len_q;
        // Bad status wins over good when both were latched.
        accept = good_lat_q & ~bad_lat_q & ~mismatch_q & ~runt_q &
                 (len_q >= LEN_MIN) & (len_q <= LEN_MAX);
        if (accept) begin
          delay_cycles_d = cap_delay_q;
          delay_valid_d  = 1'b1;
          ok_cnt_d       = sat_inc16(ok_cnt_q);
        end else begin
          err_cnt_d = sat_inc16(err_cnt_q);
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge tx_clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cap_delay_q    <= '0;
      len_q          <= '0;
      mismatch_q     <= 1'b0;
      runt_q         <= 1'b0;
      good_lat_q     <= 1'b0;
      bad_lat_q      <= 1'b0;
      wait_cnt_q     <= '0;
      dvld_prev_q    <= 1'b0;
      delay_cycles_q <= '0;
      delay_valid_q  <= 1'b0;
      frame_len_q    <= '0;
      ok_cnt_q       <= '0;
      err_cnt_q      <= '0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cap_delay_q    <= cap_delay_d;
      len_q          <= len_d;
      mismatch_q     <= mismatch_d;
      runt_q         <= runt_d;
      good_lat_q     <= good_lat_d;
      bad_lat_q      <= bad_lat_d;
      wait_cnt_q     <= wait_cnt_d;
      dvld_prev_q    <= dvld_prev_d;
      delay_cycles_q <= delay_cycles_d;
      delay_valid_q  <= delay_valid_d;
      frame_len_q    <= frame_len_d;
      ok_cnt_q       <= ok_cnt_d;
      err_cnt_q      <= err_cnt_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign delay_cycles = delay_cycles_q;
  assign delay_valid  = delay_valid_q;
  assign frame_len    = frame_len_q;
  assign rx_ok_count  = ok_cnt_q;
  assign rx_err_count = err_cnt_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire
